stream_limit: RTL and testbench

STREAM_LIMIT -- requirements
Module: stream_limit

---
 rtl/stream_limit_pkg.sv | 36 +++
 rtl/stream_limit_slew.sv | 56 +++++
 rtl/stream_limit.sv | 139 +++++++++++++
 tb/tb_stream_limit.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_limit_pkg.sv
// Shared helpers for stream_limit: signed compare, slew clamp, saturating count.
// Values are widened to XW bits so one set of helpers serves every N up to 32.
package stream_limit_pkg;

   localparam int MAXN = 32;
   localparam int XW   = MAXN + 2;

   // Operands arrive already sign- or zero-extended, so a signed compare
   // is correct for both the signed and the unsigned sample formats.
   function automatic logic lt_x(input logic signed [XW-1:0] a,
                                 input logic signed [XW-1:0] b);
      return a < b;
   endfunction

   // Delta is exact at this width; results stay within [p-st, p+st].
   function automatic logic signed [XW-1:0] slew_clamp(
      input logic signed [XW-1:0] x,
      input logic signed [XW-1:0] p,
      input logic signed [XW-1:0] st);
      logic signed [XW-1:0] d;
      d = x - p;
      if (st == '0)
         return x;
      if (d > st)
         return p + st;
      if (d < -st)
         return p - st;
      return x;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] c,
                                           input logic [31:0] top);
      return (c >= top) ? c : c + 32'd1;
   endfunction

endpackage

// File: rtl/stream_limit_slew.sv
// Per-channel slew limiter with its Prev register file.
// Ports: Clk/nReset, Step, Chan/Chan_Ok, Rng_Data in; Take commits Prev; Slew_Data/Slewed out.
module stream_limit_slew
   import stream_limit_pkg::*;
#(
   parameter int N        = 16,
   parameter int CHANNELS = 4,
   parameter int CW       = 2,
   parameter bit SIGNED   = 1'b0
) (
   input  logic          Clk,
   input  logic          nReset,
   input  logic [N-1:0]  Step,
   input  logic [CW-1:0] Chan,
   input  logic          Chan_Ok,
   input  logic [N-1:0]  Rng_Data,
   input  logic          Take,
   output logic [N-1:0]  Slew_Data,
   output logic          Slewed
);

   logic [N-1:0] prev [CHANNELS];
   logic [N-1:0] p;

   function automatic logic signed [XW-1:0] ext(input logic [N-1:0] v);
      return {{(XW-N){SIGNED && v[N-1]}}, v};
   endfunction

   always_comb begin
      p = '0;
      for (int c = 0; c < CHANNELS; c++)
         if (Chan == CW'(c))
            p = prev[c];
   end

   always_comb begin
      Slew_Data = Rng_Data;
      if (Chan_Ok)
         Slew_Data = N'(slew_clamp(ext(Rng_Data), ext(p),
                                   {{(XW-N){1'b0}}, Step}));
   end

   assign Slewed = (Slew_Data != Rng_Data);

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         for (int c = 0; c < CHANNELS; c++)
            prev[c] <= '0;
      end else if (Take && Chan_Ok) begin
         for (int c = 0; c < CHANNELS; c++)
            if (Chan == CW'(c))
               prev[c] <= Slew_Data;
      end
   end

endmodule

// File: rtl/stream_limit.sv
// Range (and optional slew) limiter for a channel-multiplexed sample stream.
// Ports: Cfg_* staged limits + Cfg_Load/Cfg_Err; In_*/Out_* valid-ready streams; Sat_Count/Sat_Clear stats.
// Define STREAM_LIMIT_SLEW_EN to add per-channel slew limiting via Cfg_Step.
module stream_limit
   import stream_limit_pkg::*;
#(
   parameter int           N          = 16,
   parameter int           CHANNELS   = 4,
   parameter bit           SIGNED     = 1'b0,
   parameter logic [N-1:0] LOWER_INIT = '0,
   parameter logic [N-1:0] UPPER_INIT = '1,
   parameter int           CNT_W      = 16,
   localparam int          CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic             nReset,
   input  logic             Clk,
   input  logic [N-1:0]     Cfg_Lower,
   input  logic [N-1:0]     Cfg_Upper,
   input  logic [N-1:0]     Cfg_Step,
   input  logic             Cfg_Load,
   output logic             Cfg_Err,
   input  logic             In_Valid,
   output logic             In_Ready,
   input  logic [CW-1:0]    In_Channel,
   input  logic [N-1:0]     In_Data,
   output logic             Out_Valid,
   input  logic             Out_Ready,
   output logic [CW-1:0]    Out_Channel,
   output logic [N-1:0]     Out_Data,
   output logic             Out_Clipped,
   output logic [CNT_W-1:0] Sat_Count,
   input  logic             Sat_Clear
);

   localparam logic [CW:0] CH_LIM = (CW+1)'(CHANNELS);

   logic [N-1:0] lower, upper;
   logic [N-1:0] rng_data, fin_data;
   logic         clip_lo, clip_hi, slewed, clipped;
   logic         in_fire, chan_ok, cfg_bad;

   function automatic logic signed [XW-1:0] ext(input logic [N-1:0] v);
      return {{(XW-N){SIGNED && v[N-1]}}, v};
   endfunction

   assign In_Ready = !Out_Valid || Out_Ready;
   assign in_fire  = In_Valid && In_Ready;
   assign chan_ok  = ({1'b0, In_Channel} < CH_LIM);

   assign clip_lo = lt_x(ext(In_Data), ext(lower));
   assign clip_hi = lt_x(ext(upper), ext(In_Data));
   assign cfg_bad = lt_x(ext(Cfg_Upper), ext(Cfg_Lower));

   always_comb begin
      rng_data = In_Data;
      if (clip_lo)
         rng_data = lower;
      else if (clip_hi)
         rng_data = upper;
   end

`ifdef STREAM_LIMIT_SLEW_EN
   logic [N-1:0] step;

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset)
         step <= '0;
      else if (Cfg_Load && !cfg_bad)
         step <= Cfg_Step;
   end

   stream_limit_slew #(
      .N        (N),
      .CHANNELS (CHANNELS),
      .CW       (CW),
      .SIGNED   (SIGNED)
   ) u_slew (
      .Clk       (Clk),
      .nReset    (nReset),
      .Step      (step),
      .Chan      (In_Channel),
      .Chan_Ok   (chan_ok),
      .Rng_Data  (rng_data),
      .Take      (in_fire),
      .Slew_Data (fin_data),
      .Slewed    (slewed)
   );
`else
   logic unused_step;
   assign unused_step = ^Cfg_Step;
   assign fin_data    = rng_data;
   assign slewed      = 1'b0;
`endif

   assign clipped = clip_lo || clip_hi || slewed;

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         Out_Valid   <= 1'b0;
         Out_Data    <= '0;
         Out_Channel <= '0;
         Out_Clipped <= 1'b0;
      end else if (in_fire) begin
         Out_Valid   <= 1'b1;
         Out_Data    <= fin_data;
         Out_Channel <= In_Channel;
         Out_Clipped <= clipped;
      end else if (Out_Ready) begin
         Out_Valid   <= 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         lower   <= LOWER_INIT;
         upper   <= UPPER_INIT;
         Cfg_Err <= 1'b0;
      end else if (Cfg_Load) begin
         if (cfg_bad) begin
            Cfg_Err <= 1'b1;
         end else begin
            lower   <= Cfg_Lower;
            upper   <= Cfg_Upper;
            Cfg_Err <= 1'b0;
         end
      end
   end

   // Out-of-range channels are passed through but never counted.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset)
         Sat_Count <= '0;
      else if (Sat_Clear)
         Sat_Count <= '0;
      else if (in_fire && chan_ok && clipped)
         Sat_Count <= CNT_W'(sat_inc(32'(Sat_Count), 32'({CNT_W{1'b1}})));
   end

endmodule

// File: tb/tb_stream_limit.sv
// Directed self-checking bench for stream_limit (unsigned and signed instances).
// Slew scenarios are compiled in when STREAM_LIMIT_SLEW_EN is defined.
module tb_stream_limit;

   logic       clk = 1'b0;
   logic       nreset = 1'b0;
   logic [7:0] cfg_lower = 8'h00, cfg_upper = 8'h00, cfg_step = 8'h00;
   logic       cfg_load = 1'b0;
   logic       in_valid = 1'b0;
   logic [1:0] in_channel = 2'd0;
   logic [7:0] in_data = 8'h00;
   logic       out_ready = 1'b1;
   logic       sat_clear = 1'b0;

   logic       a_cfg_err, a_in_ready, a_out_valid, a_out_clipped;
   logic [1:0] a_out_channel, a_sat_count;
   logic [7:0] a_out_data;
   logic       b_cfg_err, b_in_ready, b_out_valid, b_out_clipped;
   logic [1:0] b_out_channel, b_sat_count;
   logic [7:0] b_out_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stream_limit #(
      .N(8), .CHANNELS(3), .SIGNED(1'b0),
      .LOWER_INIT(8'h10), .UPPER_INIT(8'hF0), .CNT_W(2)
   ) u_a (
      .nReset(nreset), .Clk(clk),
      .Cfg_Lower(cfg_lower), .Cfg_Upper(cfg_upper), .Cfg_Step(cfg_step),
      .Cfg_Load(cfg_load), .Cfg_Err(a_cfg_err),
      .In_Valid(in_valid), .In_Ready(a_in_ready),
      .In_Channel(in_channel), .In_Data(in_data),
      .Out_Valid(a_out_valid), .Out_Ready(out_ready),
      .Out_Channel(a_out_channel), .Out_Data(a_out_data),
      .Out_Clipped(a_out_clipped),
      .Sat_Count(a_sat_count), .Sat_Clear(sat_clear)
   );

   stream_limit #(
      .N(8), .CHANNELS(3), .SIGNED(1'b1),
      .LOWER_INIT(8'hF8), .UPPER_INIT(8'h07), .CNT_W(2)
   ) u_b (
      .nReset(nreset), .Clk(clk),
      .Cfg_Lower(cfg_lower), .Cfg_Upper(cfg_upper), .Cfg_Step(cfg_step),
      .Cfg_Load(cfg_load), .Cfg_Err(b_cfg_err),
      .In_Valid(in_valid), .In_Ready(b_in_ready),
      .In_Channel(in_channel), .In_Data(in_data),
      .Out_Valid(b_out_valid), .Out_Ready(out_ready),
      .Out_Channel(b_out_channel), .Out_Data(b_out_data),
      .Out_Clipped(b_out_clipped),
      .Sat_Count(b_sat_count), .Sat_Clear(sat_clear)
   );

   task automatic xfer(input logic [1:0] ch, input logic [7:0] d);
      @(negedge clk);
      in_valid   = 1'b1;
      in_channel = ch;
      in_data    = d;
      @(negedge clk);
      in_valid   = 1'b0;
   endtask

   task automatic cfg_write(input logic [7:0] lo, input logic [7:0] hi,
                            input logic [7:0] st);
      @(negedge clk);
      cfg_lower = lo;
      cfg_upper = hi;
      cfg_step  = st;
      cfg_load  = 1'b1;
      @(negedge clk);
      cfg_load  = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({a_out_valid, a_out_clipped, a_cfg_err, a_out_channel,
           a_out_data, a_sat_count} !== 15'h0) begin
         errors++;
         $display("FAIL reset_a got %b/%b/%b/%h/%h/%h exp all zero",
                  a_out_valid, a_out_clipped, a_cfg_err, a_out_channel,
                  a_out_data, a_sat_count);
      end
      checks++;
      if ({b_out_valid, b_out_data, b_sat_count, a_in_ready} !== 12'h001) begin
         errors++;
         $display("FAIL reset_b got %b/%h/%h rdy %b exp 0/00/0 rdy 1",
                  b_out_valid, b_out_data, b_sat_count, a_in_ready);
      end
      @(negedge clk);
      nreset = 1'b1;
   endtask

   task automatic test_signed();
      xfer(2'd0, 8'h80);
      checks++;
      if ({b_out_valid, b_out_clipped, b_out_data} !== {2'b11, 8'hF8}) begin
         errors++;
         $display("FAIL signed_neg got %b/%b/%h exp 1/1/f8",
                  b_out_valid, b_out_clipped, b_out_data);
      end
      xfer(2'd0, 8'h03);
      checks++;
      if ({b_out_valid, b_out_clipped, b_out_data} !== {2'b10, 8'h03}) begin
         errors++;
         $display("FAIL signed_mid got %b/%b/%h exp 1/0/03",
                  b_out_valid, b_out_clipped, b_out_data);
      end
      xfer(2'd0, 8'h7F);
      checks++;
      if ({b_out_clipped, b_out_data} !== {1'b1, 8'h07}) begin
         errors++;
         $display("FAIL signed_pos got %b/%h exp 1/07",
                  b_out_clipped, b_out_data);
      end
   endtask

   task automatic test_range();
      logic [7:0] din  [5] = '{8'h05, 8'h80, 8'hFF, 8'h10, 8'hF0};
      logic [7:0] dexp [5] = '{8'h10, 8'h80, 8'hF0, 8'h10, 8'hF0};
      logic       cexp [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      @(negedge clk);
      sat_clear = 1'b1;
      @(negedge clk);
      sat_clear = 1'b0;
      for (int i = 0; i < 5; i++) begin
         xfer(2'd0, din[i]);
         checks++;
         if ({a_out_valid, a_out_clipped, a_out_data} !==
             {1'b1, cexp[i], dexp[i]}) begin
            errors++;
            $display("FAIL range_%0d got %b/%b/%h exp 1/%b/%h", i,
                     a_out_valid, a_out_clipped, a_out_data,
                     cexp[i], dexp[i]);
         end
      end
      checks++;
      if (a_sat_count !== 2'd2) begin
         errors++;
         $display("FAIL range_count got %0d exp 2", a_sat_count);
      end
   endtask

   task automatic test_saturate();
      xfer(2'd0, 8'h05);
      xfer(2'd0, 8'hFF);
      checks++;
      if (a_sat_count !== 2'd3) begin
         errors++;
         $display("FAIL sat_hold got %0d exp 3", a_sat_count);
      end
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = 8'h05;
      sat_clear = 1'b1;
      @(negedge clk);
      in_valid  = 1'b0;
      sat_clear = 1'b0;
      checks++;
      if ({a_out_clipped, a_sat_count} !== 3'b100) begin
         errors++;
         $display("FAIL sat_clear got %b/%0d exp 1/0",
                  a_out_clipped, a_sat_count);
      end
   endtask

   task automatic test_bad_channel();
      xfer(2'd3, 8'h05);
      checks++;
      if ({a_out_clipped, a_out_channel, a_out_data, a_sat_count} !==
          {1'b1, 2'd3, 8'h10, 2'd0}) begin
         errors++;
         $display("FAIL badch_clip got %b/%0d/%h/%0d exp 1/3/10/0",
                  a_out_clipped, a_out_channel, a_out_data, a_sat_count);
      end
      xfer(2'd3, 8'h80);
      checks++;
      if ({a_out_clipped, a_out_data} !== {1'b0, 8'h80}) begin
         errors++;
         $display("FAIL badch_pass got %b/%h exp 0/80",
                  a_out_clipped, a_out_data);
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      out_ready  = 1'b0;
      in_valid   = 1'b1;
      in_channel = 2'd1;
      in_data    = 8'h40;
      @(negedge clk);
      in_data    = 8'h50;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({a_out_valid, a_in_ready, a_out_channel, a_out_data} !==
             {2'b10, 2'd1, 8'h40}) begin
            errors++;
            $display("FAIL stall_%0d got %b/%b/%0d/%h exp 1/0/1/40", i,
                     a_out_valid, a_in_ready, a_out_channel, a_out_data);
         end
         if (i < 3)
            @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      in_valid  = 1'b0;
      checks++;
      if ({a_out_valid, a_out_data} !== {1'b1, 8'h50}) begin
         errors++;
         $display("FAIL stall_next got %b/%h exp 1/50",
                  a_out_valid, a_out_data);
      end
      @(negedge clk);
      checks++;
      if (a_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_dup got %b exp 0", a_out_valid);
      end
   endtask

   task automatic test_cfg();
      cfg_write(8'h20, 8'h10, 8'h00);
      checks++;
      if (a_cfg_err !== 1'b1) begin
         errors++;
         $display("FAIL cfg_reject got %b exp 1", a_cfg_err);
      end
      xfer(2'd0, 8'h05);
      checks++;
      if (a_out_data !== 8'h10) begin
         errors++;
         $display("FAIL cfg_old got %h exp 10", a_out_data);
      end
      cfg_write(8'h20, 8'hE0, 8'h00);
      checks++;
      if (a_cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL cfg_accept got %b exp 0", a_cfg_err);
      end
      xfer(2'd0, 8'hFF);
      checks++;
      if (a_out_data !== 8'hE0) begin
         errors++;
         $display("FAIL cfg_new got %h exp e0", a_out_data);
      end
      @(negedge clk);
      cfg_lower  = 8'h30;
      cfg_upper  = 8'hE0;
      cfg_load   = 1'b1;
      in_valid   = 1'b1;
      in_channel = 2'd0;
      in_data    = 8'h25;
      @(negedge clk);
      cfg_load   = 1'b0;
      in_valid   = 1'b0;
      checks++;
      if ({a_out_clipped, a_out_data} !== {1'b0, 8'h25}) begin
         errors++;
         $display("FAIL cfg_same_edge got %b/%h exp 0/25",
                  a_out_clipped, a_out_data);
      end
      xfer(2'd0, 8'h25);
      checks++;
      if ({a_out_clipped, a_out_data} !== {1'b1, 8'h30}) begin
         errors++;
         $display("FAIL cfg_after got %b/%h exp 1/30",
                  a_out_clipped, a_out_data);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      out_ready  = 1'b0;
      in_valid   = 1'b1;
      in_channel = 2'd2;
      in_data    = 8'h77;
      @(negedge clk);
      in_valid   = 1'b0;
      nreset     = 1'b0;
      #1;
      checks++;
      if ({a_out_valid, a_out_data} !== 9'h0) begin
         errors++;
         $display("FAIL rst_mid got %b/%h exp 0/00",
                  a_out_valid, a_out_data);
      end
      @(negedge clk);
      nreset    = 1'b1;
      out_ready = 1'b1;
      xfer(2'd0, 8'h20);
      checks++;
      if ({a_out_valid, a_out_clipped, a_out_data} !== {2'b10, 8'h20}) begin
         errors++;
         $display("FAIL rst_first got %b/%b/%h exp 1/0/20",
                  a_out_valid, a_out_clipped, a_out_data);
      end
   endtask

`ifdef STREAM_LIMIT_SLEW_EN
   task automatic test_slew();
      logic [7:0] e;
      cfg_write(8'h10, 8'hF0, 8'h04);
      for (int r = 0; r < 3; r++) begin
         e = 8'(4 * (r + 1));
         xfer(2'd1, 8'h20);
         checks++;
         if ({a_out_clipped, a_out_channel, a_out_data} !==
             {1'b1, 2'd1, e}) begin
            errors++;
            $display("FAIL slew_c1_%0d got %b/%0d/%h exp 1/1/%h", r,
                     a_out_clipped, a_out_channel, a_out_data, e);
         end
         xfer(2'd2, 8'h10);
         checks++;
         if ({a_out_clipped, a_out_channel, a_out_data} !==
             {1'b1, 2'd2, e}) begin
            errors++;
            $display("FAIL slew_c2_%0d got %b/%0d/%h exp 1/2/%h", r,
                     a_out_clipped, a_out_channel, a_out_data, e);
         end
      end
      xfer(2'd3, 8'h80);
      checks++;
      if ({a_out_clipped, a_out_data} !== {1'b0, 8'h80}) begin
         errors++;
         $display("FAIL slew_badch got %b/%h exp 0/80",
                  a_out_clipped, a_out_data);
      end
      xfer(2'd1, 8'h10);
      checks++;
      if ({a_out_clipped, a_out_data} !== {1'b0, 8'h10}) begin
         errors++;
         $display("FAIL slew_edge got %b/%h exp 0/10",
                  a_out_clipped, a_out_data);
      end
      cfg_write(8'h10, 8'hF0, 8'h00);
      xfer(2'd2, 8'hA0);
      checks++;
      if ({a_out_clipped, a_out_data} !== {1'b0, 8'hA0}) begin
         errors++;
         $display("FAIL slew_bypass got %b/%h exp 0/a0",
                  a_out_clipped, a_out_data);
      end
   endtask
`else
   task automatic test_slew();
      cfg_write(8'h10, 8'hF0, 8'h04);
      xfer(2'd1, 8'h20);
      checks++;
      if ({a_out_clipped, a_out_data} !== {1'b0, 8'h20}) begin
         errors++;
         $display("FAIL noslew got %b/%h exp 0/20",
                  a_out_clipped, a_out_data);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_signed();
      test_range();
      test_saturate();
      test_bad_channel();
      test_backpressure();
      test_cfg();
      test_reset_mid();
      test_slew();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
